// File: rtl/gp_reg_arbiter.sv
// gp_reg_arbiter: shares one bank of general-purpose registers between two
// requesters (A and B). A request is granted with round-robin priority, then
// sequenced as setup (GRANT), write strobe (STROBE), hold (RELEASE) and a
// one-cycle acknowledge (ACK). Every output comes straight from a flop that is
// loaded together with the FSM state, so outputs always describe the current
// state.
module gp_reg_arbiter #(
    parameter int bus_width  = 15,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_W     = 2,
    parameter int STROBE_CYC = 2
) (
    input  logic                              sysclk,
    input  logic                              reset,
    input  logic                              req_a,
    input  logic                              we_a,
    input  logic [ADDR_W-1:0]                 addr_a,
    input  logic [bus_width:0]                wdata_a,
    output logic                              ack_a,
    output logic [bus_width:0]                rdata_a,
    input  logic                              req_b,
    input  logic                              we_b,
    input  logic [ADDR_W-1:0]                 addr_b,
    input  logic [bus_width:0]                wdata_b,
    output logic                              ack_b,
    output logic [bus_width:0]                rdata_b,
    output logic [NUM_REGS-1:0]               reg_sel,
    output logic                              wrb,
    output logic [bus_width:0]                reg_din,
    input  logic [NUM_REGS*(bus_width+1)-1:0] reg_dout,
    output logic                              busy
);

    localparam int DW    = bus_width + 1;
    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_b_q, last_b_d;   // 1: B was granted last
    logic               win_b_q, win_b_d;     // 1: current transaction is B's
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DW-1:0]      wdata_q, wdata_d;

    logic [NUM_REGS-1:0] sel_q, sel_d;
    logic                wrb_q, wrb_d;
    logic [DW-1:0]       din_q, din_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic [DW-1:0]       rdata_a_q, rdata_a_d;
    logic [DW-1:0]       rdata_b_q, rdata_b_d;
    logic                busy_q, busy_d;

    // Arbitration: a lone requester wins; on a tie the side not granted last wins.
    logic                pick_b;
    logic                cand_we;
    logic [ADDR_W-1:0]   cand_addr;
    logic [DW-1:0]       cand_wdata;
    logic [NUM_REGS-1:0] cand_hot;
    logic [NUM_REGS-1:0] cur_hot;
    logic [DW-1:0]       dout_slice [NUM_REGS];
    logic [DW-1:0]       rd_slice;

    assign pick_b     = req_b & (~req_a | ~last_b_q);
    assign cand_we    = pick_b ? we_b    : we_a;
    assign cand_addr  = pick_b ? addr_b  : addr_a;
    assign cand_wdata = pick_b ? wdata_b : wdata_a;

    // One-hot decode; an out-of-range address decodes to all zeros, which
    // automatically suppresses both the select and the write strobe.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_decode
        assign cand_hot[gi]   = (cand_addr == ADDR_W'(gi));
        assign cur_hot[gi]    = (addr_q == ADDR_W'(gi));
        assign dout_slice[gi] = reg_dout[gi*DW +: DW];
    end

    // Read-back mux for the latched address; zero when out of range.
    always_comb begin
        rd_slice = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_hot[i]) begin
                rd_slice = dout_slice[i];
            end
        end
    end

    // Next-state and next-output logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_b_d  = last_b_q;
        win_b_d   = win_b_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        sel_d     = sel_q;
        wrb_d     = 1'b1;
        din_d     = din_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        busy_d    = busy_q;

        case (state_q)
            ST_IDLE: begin
                sel_d  = '0;
                busy_d = 1'b0;
                if (req_a || req_b) begin
                    state_d  = ST_GRANT;
                    win_b_d  = pick_b;
                    last_b_d = pick_b;
                    we_d     = cand_we;
                    addr_d   = cand_addr;
                    wdata_d  = cand_wdata;
                    sel_d    = cand_hot;
                    din_d    = cand_wdata;
                    busy_d   = 1'b1;
                end
            end
            ST_GRANT: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(STROBE_CYC - 1);
                wrb_d   = ~(we_q & (|sel_q));
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RELEASE;
                    if (!we_q) begin
                        if (win_b_q) begin
                            rdata_b_d = rd_slice;
                        end else begin
                            rdata_a_d = rd_slice;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    wrb_d = ~(we_q & (|sel_q));
                end
            end
            ST_RELEASE: begin
                state_d = ST_ACK;
                sel_d   = '0;
                ack_a_d = ~win_b_q;
                ack_b_d = win_b_q;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched request and output registers; reset drops any transaction.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last_b_q  <= 1'b1;
            win_b_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            wrb_q     <= 1'b1;
            din_q     <= '0;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_b_q  <= last_b_d;
            win_b_q   <= win_b_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            wrb_q     <= wrb_d;
            din_q     <= din_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            busy_q    <= busy_d;
        end
    end

    assign reg_sel = sel_q;
    assign wrb     = wrb_q;
    assign reg_din = din_q;
    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_gp_reg_arbiter.sv
// Testbench for gp_reg_arbiter. Three instances cover the default build,
// a 3-register bank with a 4-cycle strobe, and a 1-cycle strobe. Stimulus
// pushes expected transactions into a scoreboard queue; a negedge monitor
// checks every cycle's outputs against a timeline computed from the grant
// edge, and pops/compares an entry when an acknowledge is due or seen.
module tb_gp_reg_arbiter;

    localparam int NI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic        req_a   [NI];
    logic        we_a    [NI];
    logic [1:0]  addr_a  [NI];
    logic [15:0] wdata_a [NI];
    logic        req_b   [NI];
    logic        we_b    [NI];
    logic [1:0]  addr_b  [NI];
    logic [15:0] wdata_b [NI];
    logic [63:0] dout    [NI];

    logic        ack_a   [NI];
    logic        ack_b   [NI];
    logic [15:0] rdata_a [NI];
    logic [15:0] rdata_b [NI];
    logic [3:0]  sel     [NI];
    logic        wrb     [NI];
    logic [15:0] din     [NI];
    logic        busy    [NI];

    typedef struct {
        int          inst;
        bit          side;   // 0 = A, 1 = B
        int          s;      // cycle count right after the granting edge
        bit          we;
        int          addr;
        logic [15:0] wdata;
        logic [15:0] rda;    // rdata_a expected at this ack
        logic [15:0] rdb;    // rdata_b expected at this ack
    } exp_t;

    exp_t        exp_q [$];
    logic [15:0] m_rda    [NI];
    logic [15:0] m_rdb    [NI];
    bit          m_last_b [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int NR = (gi == 1) ? 3 : 4;
        localparam int SC = (gi == 0) ? 2 : ((gi == 1) ? 4 : 1);
        logic [NR-1:0] sel_w;
        gp_reg_arbiter #(
            .bus_width (15),
            .NUM_REGS  (NR),
            .ADDR_W    (2),
            .STROBE_CYC(SC)
        ) u_dut (
            .sysclk  (clk),
            .reset   (rst_n),
            .req_a   (req_a[gi]),
            .we_a    (we_a[gi]),
            .addr_a  (addr_a[gi]),
            .wdata_a (wdata_a[gi]),
            .ack_a   (ack_a[gi]),
            .rdata_a (rdata_a[gi]),
            .req_b   (req_b[gi]),
            .we_b    (we_b[gi]),
            .addr_b  (addr_b[gi]),
            .wdata_b (wdata_b[gi]),
            .ack_b   (ack_b[gi]),
            .rdata_b (rdata_b[gi]),
            .reg_sel (sel_w),
            .wrb     (wrb[gi]),
            .reg_din (din[gi]),
            .reg_dout(dout[gi][NR*16-1:0]),
            .busy    (busy[gi])
        );
        assign sel[gi] = 4'(sel_w);
    end

    function automatic int nr_of(input int k);
        return (k == 1) ? 3 : 4;
    endfunction

    function automatic int sc_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 4 : 1);
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", name, k, $time, act, req);
    endtask

    // Reference effect of one transaction on the held read data.
    task automatic push_txn(input int k, input bit side, input int s, input bit we,
                            input logic [1:0] addr, input logic [15:0] wdata, input logic [63:0] dv);
        exp_t        e;
        logic [15:0] val;
        int          a;
        a = int'(addr);
        if (!we) begin
            val = (a < nr_of(k)) ? dv[a*16 +: 16] : 16'h0000;
            if (side) m_rdb[k] = val;
            else      m_rda[k] = val;
        end
        e.inst = k; e.side = side; e.s = s; e.we = we; e.addr = a; e.wdata = wdata;
        e.rda = m_rda[k]; e.rdb = m_rdb[k];
        exp_q.push_back(e);
    endtask

    task automatic do_round(input int k, input bit ra, input bit rb, input bit wa, input bit wb,
                            input logic [1:0] aa, input logic [1:0] ab,
                            input logic [15:0] da, input logic [15:0] db, input logic [63:0] dv);
        int s0, n, budget;
        bit first_b, done_a, done_b, pend_a, pend_b;
        @(posedge clk); #1;
        dout[k] = dv;
        req_a[k] = ra; we_a[k] = wa; addr_a[k] = aa; wdata_a[k] = da;
        req_b[k] = rb; we_b[k] = wb; addr_b[k] = ab; wdata_b[k] = db;
        s0 = cyc + 1;
        first_b = (ra && rb) ? !m_last_b[k] : rb;
        if (first_b) push_txn(k, 1'b1, s0, wb, ab, db, dv);
        else         push_txn(k, 1'b0, s0, wa, aa, da, dv);
        if (ra && rb) begin
            if (first_b) push_txn(k, 1'b0, s0 + sc_of(k) + 4, wa, aa, da, dv);
            else         push_txn(k, 1'b1, s0 + sc_of(k) + 4, wb, ab, db, dv);
            m_last_b[k] = !first_b;
        end else begin
            m_last_b[k] = first_b;
        end
        done_a = !ra; done_b = !rb; pend_a = 1'b0; pend_b = 1'b0;
        n = 0; budget = 2 * (sc_of(k) + 5) + 10;
        while (!(done_a && done_b) && n < budget) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin
                // the winner's inputs change after its grant and must be ignored
                if (first_b) begin
                    we_b[k] = 1'($urandom); addr_b[k] = 2'($urandom); wdata_b[k] = 16'($urandom);
                end else begin
                    we_a[k] = 1'($urandom); addr_a[k] = 2'($urandom); wdata_a[k] = 16'($urandom);
                end
            end
            if (pend_a) begin
                req_a[k] = 1'b0; done_a = 1'b1; pend_a = 1'b0;
            end else if (!done_a && ack_a[k]) begin
                pend_a = 1'b1;
            end
            if (pend_b) begin
                req_b[k] = 1'b0; done_b = 1'b1; pend_b = 1'b0;
            end else if (!done_b && ack_b[k]) begin
                pend_b = 1'b1;
            end
        end
        n_total++;
        if (done_a && done_b) begin
            n_pass++;
        end else begin
            $display("FAIL round_timeout inst%0d: acks done a=%0d b=%0d, required 1 1", k, done_a, done_b);
            req_a[k] = 1'b0; req_b[k] = 1'b0;
            exp_q.delete();
        end
        chk("queue_drained", k, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: per-cycle output timeline check and scoreboard pop on ack.
    exp_t       mon_e;
    int         mon_d, mon_sc;
    bit         mon_act, mon_inr;
    logic [3:0] sel_e;
    logic       wrb_e, busy_e;
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < NI; k++) begin
                mon_act = (exp_q.size() > 0) && (exp_q[0].inst == k);
                mon_sc  = sc_of(k);
                mon_d   = 0;
                if (mon_act) begin
                    mon_e   = exp_q[0];
                    mon_d   = cyc - mon_e.s;
                    mon_inr = (mon_e.addr < nr_of(k));
                    busy_e  = (mon_d >= 0) && (mon_d <= mon_sc + 2);
                    sel_e   = (mon_inr && mon_d >= 0 && mon_d <= mon_sc + 1) ? 4'(1 << mon_e.addr) : 4'd0;
                    wrb_e   = !(mon_e.we && mon_inr && mon_d >= 1 && mon_d <= mon_sc);
                    if (mon_d >= 0 && mon_d <= mon_sc + 1)
                        chk("reg_din", k, 64'(din[k]), 64'(mon_e.wdata));
                end else begin
                    busy_e = 1'b0;
                    sel_e  = 4'd0;
                    wrb_e  = 1'b1;
                end
                chk("busy", k, 64'(busy[k]), 64'(busy_e));
                chk("reg_sel", k, 64'(sel[k]), 64'(sel_e));
                chk("wrb", k, 64'(wrb[k]), 64'(wrb_e));
                if (mon_act && (ack_a[k] || ack_b[k] || mon_d >= mon_sc + 2)) begin
                    chk("ack_cycle", k, 64'(mon_d), 64'(mon_sc + 2));
                    chk("ack_ab", k, 64'({ack_a[k], ack_b[k]}), mon_e.side ? 64'd1 : 64'd2);
                    chk("rdata_a", k, 64'(rdata_a[k]), 64'(mon_e.rda));
                    chk("rdata_b", k, 64'(rdata_b[k]), 64'(mon_e.rdb));
                    $display("txn inst%0d %s %s addr=%0d wdata=%h rdata_a=%h rdata_b=%h",
                             k, mon_e.side ? "B" : "A", mon_e.we ? "wr" : "rd",
                             mon_e.addr, mon_e.wdata, rdata_a[k], rdata_b[k]);
                    void'(exp_q.pop_front());
                end else begin
                    chk("ack_idle", k, 64'({ack_a[k], ack_b[k]}), 64'd0);
                end
            end
        end
    end

    task automatic chk_reset_vals(input int k);
        chk("rst_wrb", k, 64'(wrb[k]), 64'd1);
        chk("rst_reg_sel", k, 64'(sel[k]), 64'd0);
        chk("rst_reg_din", k, 64'(din[k]), 64'd0);
        chk("rst_ack", k, 64'({ack_a[k], ack_b[k]}), 64'd0);
        chk("rst_rdata_a", k, 64'(rdata_a[k]), 64'd0);
        chk("rst_rdata_b", k, 64'(rdata_b[k]), 64'd0);
        chk("rst_busy", k, 64'(busy[k]), 64'd0);
    endtask

    initial begin
        int   s0, n, k;
        bit   ra, rb;
        for (int i = 0; i < NI; i++) begin
            req_a[i] = 1'b0; we_a[i] = 1'b0; addr_a[i] = 2'd0; wdata_a[i] = 16'h0;
            req_b[i] = 1'b0; we_b[i] = 1'b0; addr_b[i] = 2'd0; wdata_b[i] = 16'h0;
            dout[i] = 64'h0;
            m_rda[i] = 16'h0; m_rdb[i] = 16'h0; m_last_b[i] = 1'b1;
        end
        #1 rst_n = 1'b0;
        #20;
        for (int i = 0; i < NI; i++) chk_reset_vals(i);
        @(posedge clk); #3 rst_n = 1'b1;

        // Default build: A write, B read, then repeated ties (A,B,A,B).
        do_round(0, 1, 0, 1, 0, 2'd2, 2'd0, 16'h1234, 16'h0, 64'h0);
        do_round(0, 0, 1, 0, 0, 2'd0, 2'd1, 16'h0, 16'h0, 64'h0000_0000_BEEF_0000);
        do_round(0, 1, 1, 1, 0, 2'd0, 2'd3, 16'hC001, 16'h0, 64'h7777_0000_0000_0000);
        do_round(0, 1, 1, 0, 1, 2'd3, 2'd1, 16'h0, 16'hD00D, 64'h1111_2222_3333_4444);

        // 3-register bank, 4-cycle strobe: out-of-range write and read.
        do_round(1, 1, 0, 1, 0, 2'd3, 2'd0, 16'hFACE, 16'h0, 64'h0);
        do_round(1, 1, 0, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 64'h0000_0000_0000_5A5A);
        do_round(1, 1, 0, 0, 0, 2'd3, 2'd0, 16'h0, 16'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_round(1, 0, 1, 1, 1, 2'd0, 2'd1, 16'h0, 16'h4321, 64'h0);

        // 1-cycle strobe.
        do_round(2, 1, 0, 1, 0, 2'd1, 2'd0, 16'h0F0F, 16'h0, 64'h0);
        do_round(2, 0, 1, 0, 0, 2'd0, 2'd3, 16'h0, 16'h0, 64'h9876_0000_0000_0000);

        // Randomized traffic across all instances.
        for (int r = 0; r < 60; r++) begin
            k = int'($urandom_range(0, 2));
            n = int'($urandom_range(1, 3));
            ra = n[0]; rb = n[1];
            do_round(k, ra, rb, 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
                     16'($urandom), 16'($urandom), {$urandom, $urandom});
        end

        // Reset during the second strobe cycle of a write on the default build.
        @(posedge clk); #1;
        dout[0] = 64'h0;
        req_a[0] = 1'b1; we_a[0] = 1'b1; addr_a[0] = 2'd0; wdata_a[0] = 16'hA5A5;
        s0 = cyc + 1;
        push_txn(0, 1'b0, s0, 1'b1, 2'd0, 16'hA5A5, 64'h0);
        n = 0;
        while (cyc < s0 + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("pre_reset_wrb", 0, 64'(wrb[0]), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals(0);
        exp_q.delete();
        req_a[0] = 1'b0;
        for (int i = 0; i < NI; i++) begin
            m_rda[i] = 16'h0; m_rdb[i] = 16'h0; m_last_b[i] = 1'b1;
        end
        @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        do_round(0, 1, 1, 0, 0, 2'd1, 2'd2, 16'h0, 16'h0, 64'h0000_2222_1111_0000);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gp_reg_arbiter.md
Name: gp_reg_arbiter

Overview:
- Two-port arbiter and sequencer that shares one bank of general-purpose registers between two requesters, A and B.
- Each register is a row of wbit1 cells, enabled by one bit of a select vector and written by the active-low strobe wrb.
- The block accepts a read or write request, grants one requester with round-robin priority, and drives the one-hot register select, write data and a timed wrb pulse.
- It returns read-back data and a one-cycle acknowledge.

Parameters:
- bus_width, 15: MSB index of the data bus (data width = bus_width+1).
- NUM_REGS, 4: number of registers in the bank; one select bit each.
- ADDR_W, 2: address width; must satisfy 2**ADDR_W >= NUM_REGS.
- STROBE_CYC, 2: number of cycles wrb is held low; legal range 1..15.

Ports:
- sysclk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_a  in  1  request from A; held high until ack_a is seen.
- we_a  in  1  write (1) or read (0); valid while req_a is high.
- addr_a  in  ADDR_W  register index for A.
- wdata_a  in  bus_width+1  write data for A.
- ack_a  out  1  one-cycle completion pulse to A.
- rdata_a  out  bus_width+1  read data for A.
- req_b, we_b, addr_b, wdata_b, ack_b, rdata_b: same as the A ports, for requester B.
- reg_sel  out  NUM_REGS  one-hot register enables.
- wrb  out  1  active-low write strobe to the bank.
- reg_din  out  bus_width+1  data driven to the bank.
- reg_dout  in  NUM_REGS*(bus_width+1)  concatenated read-back; register i occupies bits [i*(bus_width+1) +: bus_width+1].
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- All outputs are registered.
- Reset values: wrb=1, reg_sel=0, reg_din=0, ack_a=ack_b=0, rdata_a=rdata_b=0, busy=0, FSM in IDLE, last_grant=B (so A wins the first tie).
- FSM states: IDLE, GRANT, STROBE, RELEASE, ACK.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that requester.
  - Both requesting: grant the requester that is not last_grant.
  - On grant: latch we, addr and wdata of the winner, update last_grant, go to GRANT.
- GRANT (1 cycle):
  - reg_sel = one-hot(addr); reg_din = latched wdata; wrb stays 1 (setup cycle).
  - Load the strobe counter with STROBE_CYC-1.
- STROBE (STROBE_CYC cycles):
  - reg_sel and reg_din held.
  - Write: wrb=0. Read: wrb=1.
  - Counter decrements each cycle; leave for RELEASE when it reaches 0.
  - Read: on the final STROBE edge, capture the selected reg_dout slice into the winner's rdata.
- RELEASE (1 cycle): wrb=1; reg_sel and reg_din still held (hold time).
- ACK (1 cycle):
  - Winner's ack=1; reg_sel=0; next state IDLE.
  - Requesters drop req on the edge that ends the ACK cycle. A req still high in the following IDLE cycle is a new request.
- Latency: req sampled high at edge N gives GRANT at N+1, STROBE from N+2 to N+1+STROBE_CYC, RELEASE at N+2+STROBE_CYC, ACK at N+3+STROBE_CYC. With defaults, ack arrives 5 cycles after the sampling edge.
- rdata is held until the next read completes for the same requester. A write never alters rdata.
- Out-of-range address (addr >= NUM_REGS):
  - Full FSM sequence and timing, but reg_sel stays 0 and wrb stays 1.
  - Read returns rdata = 0; ack is still issued.
- Changes to a requester's inputs after its grant are ignored. Requests from the loser wait; there is no queueing beyond the req level.
- Only one of ack_a or ack_b is ever high, and never both.
- Invariants: reg_sel is one-hot or zero. wrb=0 only in STROBE with reg_sel non-zero.
- Reset mid-transaction:
  - Asynchronous return to the reset values; wrb deasserts immediately.
  - The transaction is dropped and no ack is issued; requesters must re-issue.

Test Plan:
- Reset, then A writes 0x1234 to addr 2 (defaults):
  - GRANT at N+1 with reg_sel=4'b0100, reg_din=0x1234.
  - wrb=0 for exactly 2 cycles (N+2, N+3).
  - ack_a at N+5; B's outputs unchanged.
- B reads addr 1 with reg_dout slice 1 = 0xBEEF: wrb stays 1, rdata_b=0xBEEF when ack_b rises, ack_b lasts one cycle.
- req_a and req_b rise in the same cycle, first and repeatedly:
  - After reset, grant order is A, B, A, B.
  - No ack overlap; busy stays high during each transaction.
- A writes to addr 3 with NUM_REGS=3: reg_sel=0 and wrb=1 throughout, ack_a at N+5. A read to addr 3 returns rdata_a=0.
- reset driven low during the second STROBE cycle of a write:
  - wrb=1 and reg_sel=0 within the same cycle, with no ack.
  - After release, A gets the grant again on re-request.
- STROBE_CYC=1 and STROBE_CYC=4: wrb low for exactly 1 or 4 cycles, ack at N+4 or N+7.
